arb_requester: RTL and testbench
================================

# arb_requester

Client-side agent for the two-requester round-robin arbiter's req/gnt handshake. It queues transfer jobs and raises `req` until the arbiter grants. It then issues one data beat per granted cycle until the job length is exhausted, and drops `req` for one cycle so the arbiter can re-arbitrate. Each arbiter port gets one instance, wired `req`→`req_N` and `gnt_N`→`gnt`.

## Interface
- `DEPTH`, 4: job FIFO entries (power of 2, ≥2)
- `LEN_W`, 4: job length field width; beats per job = `job_len`+1 (1..2^LEN_W)
- `TIMEOUT`, 15: max consecutive REQ cycles without grant before retry (1..255)

- `clock` in 1: single clock; all state changes on rising edge
- `reset` in 1: asynchronous, active-low; clears all state immediately
- `job_valid` in 1: job offer
- `job_len` in LEN_W: beats-1 for offered job
- `job_ready` out 1: FIFO not full; job accepted on edge where `job_valid`&&`job_ready`
- `req` out 1: request to arbiter
- `gnt` in 1: grant from arbiter
- `beat` out 1: data beat this cycle
- `beat_idx` out LEN_W: index of current beat, 0-based
- `last` out 1: current beat is final beat of job
- `job_done` out 1: one-cycle pulse after final beat
- `timeout` out 1: one-cycle pulse on grant-wait timeout
- `busy` out 1: state≠IDLE or FIFO non-empty
- `fifo_count` out clog2(DEPTH)+1: queued jobs, including job in progress

## Operation
- Reset values: `req`=0, `beat`=0, `beat_idx`=0, `last`=0, `job_done`=0, `timeout`=0, `busy`=0, `fifo_count`=0, `job_ready`=1, state IDLE, FIFO empty.
- FIFO: head entry stays in place until its job completes. Pop happens on the edge leaving XFER after the final beat. Simultaneous push and pop leaves `fifo_count` unchanged. A push while full is impossible because `job_ready`=0.
- States:
  - IDLE:
    - `req`=0.
    - FIFO non-empty → REQ.
  - REQ:
    - `req`=1. Wait counter increments each cycle.
    - `gnt`=1 → XFER; beat counter cleared.
    - Wait counter reaching TIMEOUT with `gnt`=0 → REL; `timeout` pulses and the job stays queued.
  - XFER:
    - `req`=1.
    - Each cycle with `gnt`=1: `beat`=1 and `beat_idx`=beat counter; the counter increments on the edge.
    - `gnt`=0: stall with `beat`=0; `req` held and counter held.
    - Beat with counter==head `job_len`: `last`=1. Next edge → REL, pop FIFO, `job_done`=1 for one cycle.
  - REL:
    - `req`=0 for exactly one cycle.
    - Next state REQ if FIFO non-empty after the pop, else IDLE.
    - Wait counter cleared.
- `req` decodes from the state register only (glitch-free). `beat` and `last` are combinational from state, counter and `gnt`.
- Counters do not wrap: the beat counter stops at `job_len`; the wait counter is cleared on leaving REQ.
- Reset asserted mid-job: `req` falls immediately, all queued jobs are discarded, and no `job_done` is issued.

## Timing
- Job accepted at edge k into an empty idle block: `req`=1 from edge k+1.
- `gnt` sampled high at edge m in REQ: first `beat` in the cycle after edge m, provided `gnt` is still 1.
- With continuous grant, a job of L+1 beats occupies L+1 consecutive `beat` cycles. `req` then falls for one cycle, and back-to-back jobs re-assert `req` one cycle later.
- `job_done` pulses in the REL cycle.
- `timeout` pulses in the REL cycle following TIMEOUT ungranted REQ cycles.

## Test plan
- Reset low mid-XFER (`beat_idx`=2): `req`, `beat` and `fifo_count` go to 0 asynchronously; after release the block sits in IDLE with `job_ready`=1.
- Single job `job_len`=3 with `gnt` held 1 after `req`: exactly 4 `beat` cycles with `beat_idx` 0,1,2,3; `last` only on idx 3; one `job_done`; `req` low exactly 1 cycle; then IDLE.
- Grant toggling 1,0,0,1,1 during `job_len`=2: beats occur only in `gnt`=1 cycles, `req` stays high throughout, and `job_done` follows the third beat.
- Push 5 jobs with DEPTH=4: `job_ready`=0 after 4; the 5th is accepted on the same edge as the first pop; `fifo_count` steps 4→4→3→...→0; all jobs complete in order with their lengths.
- `gnt` held 0 with TIMEOUT=15: `timeout` pulses after 15 REQ cycles, `req` is 0 for one cycle and then re-asserts, and `fifo_count` is unchanged.
- Two instances on the arbiter with simultaneous jobs (`job_len`=1 each): both complete, grants never overlap, and each `job_done` pulses exactly once.

Source files
------------

// File: rtl/arb_requester_if.sv
// -----------------------------------------------------------------------------
// arb_requester_if
// Bundles the job-offer, arbiter handshake and beat-stream signals of one
// arb_requester instance.
//   master : the requester (drives job_ready, req, beat stream, status)
//   slave  : the job source / arbiter side (drives job_valid, job_len, gnt)
// Parameters:
//   DEPTH  job FIFO entries; sets the width of fifo_count
//   LEN_W  job length / beat index width
// -----------------------------------------------------------------------------
interface arb_requester_if #(
    parameter int DEPTH = 4,
    parameter int LEN_W = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             job_valid;
    logic [LEN_W-1:0] job_len;
    logic             job_ready;
    logic             req;
    logic             gnt;
    logic             beat;
    logic [LEN_W-1:0] beat_idx;
    logic             last;
    logic             job_done;
    logic             timeout;
    logic             busy;
    logic [CNT_W-1:0] fifo_count;

    modport master (
        input  job_valid, job_len, gnt,
        output job_ready, req, beat, beat_idx, last, job_done, timeout, busy, fifo_count
    );

    modport slave (
        output job_valid, job_len, gnt,
        input  job_ready, req, beat, beat_idx, last, job_done, timeout, busy, fifo_count
    );
endinterface

// File: rtl/arb_requester.sv
// -----------------------------------------------------------------------------
// arb_requester
// Client-side agent for one port of a two-requester round-robin arbiter.
// Jobs (a beat count minus one) are queued in a small FIFO. For the head job
// the block raises req, waits for gnt, emits one beat per granted cycle, then
// drops req for one cycle so the arbiter can re-arbitrate. An ungranted wait
// of TIMEOUT cycles also drops req for one cycle and retries the same job.
// Ports:
//   clock  single clock, rising edge
//   reset  asynchronous, active-low; clears all state and the queue
//   bus    arb_requester_if.master:
//            job_valid/job_len/job_ready  job offer handshake
//            req/gnt                      arbiter handshake
//            beat/beat_idx/last           per-cycle beat stream
//            job_done/timeout             one-cycle status pulses
//            busy/fifo_count              activity and queue occupancy
// -----------------------------------------------------------------------------
module arb_requester #(
    parameter int DEPTH   = 4,
    parameter int LEN_W   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic            clock,
    input  logic            reset,
    arb_requester_if.master bus
);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int WAIT_W = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_XFER = 2'd2,
        S_REL  = 2'd3
    } state_t;

    state_t              r_state;
    logic [LEN_W-1:0]    r_mem [DEPTH];
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [CNT_W-1:0]    r_count;
    logic [LEN_W-1:0]    r_beat_cnt;
    logic [WAIT_W-1:0]   r_wait_cnt;
    logic                r_job_done;
    logic                r_timeout;

    logic [LEN_W-1:0]    w_head_len;
    logic                w_beat;
    logic                w_last;
    logic                w_full;
    logic                w_job_ready;
    logic                w_push;

    // The head entry stays in place for the whole job, so its length can be
    // read directly from the array.
    assign w_head_len  = r_mem[r_rd_ptr];
    assign w_beat      = (r_state == S_XFER) && bus.gnt;
    assign w_last      = w_beat && (r_beat_cnt == w_head_len);
    assign w_full      = (r_count == CNT_W'(DEPTH));
    // A full queue still takes a job on the edge that retires the head, so
    // the slot freed by the pop is refilled in the same cycle.
    assign w_job_ready = !w_full || w_last;
    assign w_push      = bus.job_valid && w_job_ready;

    assign bus.job_ready  = w_job_ready;
    assign bus.req        = (r_state == S_REQ) || (r_state == S_XFER);
    assign bus.beat       = w_beat;
    assign bus.beat_idx   = w_beat ? r_beat_cnt : '0;
    assign bus.last       = w_last;
    assign bus.job_done   = r_job_done;
    assign bus.timeout    = r_timeout;
    assign bus.busy       = (r_state != S_IDLE) || (r_count != '0);
    assign bus.fifo_count = r_count;

    // Job storage: no reset needed, occupancy is tracked by the pointers.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= bus.job_len;
        end
    end

    // Queue pointers and occupancy. The pop is the final beat of the job.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_last) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_last})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Handshake state machine with registered status pulses.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_beat_cnt <= '0;
            r_wait_cnt <= '0;
            r_job_done <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            r_job_done <= 1'b0;
            r_timeout  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (r_count != '0) begin
                        r_state    <= S_REQ;
                        r_wait_cnt <= '0;
                    end
                end
                S_REQ: begin
                    if (bus.gnt) begin
                        r_state    <= S_XFER;
                        r_beat_cnt <= '0;
                        r_wait_cnt <= '0;
                    end else if (r_wait_cnt == WAIT_W'(TIMEOUT - 1)) begin
                        // TIMEOUT ungranted cycles spent here; head job stays queued.
                        r_state    <= S_REL;
                        r_timeout  <= 1'b1;
                        r_wait_cnt <= '0;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
                    end
                end
                S_XFER: begin
                    if (w_last) begin
                        // Counter holds at job_len; it is cleared on the next grant.
                        r_state    <= S_REL;
                        r_job_done <= 1'b1;
                    end else if (w_beat) begin
                        r_beat_cnt <= r_beat_cnt + LEN_W'(1);
                    end
                end
                S_REL: begin
                    // r_count already reflects the pop made on entry.
                    r_state    <= (r_count != '0) ? S_REQ : S_IDLE;
                    r_wait_cnt <= '0;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_arb_requester.sv
module tb_arb_requester;
    localparam int DEPTH   = 4;
    localparam int LEN_W   = 4;
    localparam int TIMEOUT = 15;
    localparam int CNT_W   = $clog2(DEPTH) + 1;

    localparam int P_IDLE = 0;
    localparam int P_REQ  = 1;
    localparam int P_XFER = 2;
    localparam int P_REL  = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    // Stimulus
    logic [1:0]       jv = 2'b00;
    logic [LEN_W-1:0] jl [2];
    logic [1:0]       dg = 2'b00;
    logic             mode_arb = 1'b0;
    logic             owner;

    // Observed
    logic [1:0]       o_req, o_beat, o_last, o_done, o_to, o_busy, o_rdy, g;
    logic [LEN_W-1:0] o_idx [2];
    logic [CNT_W-1:0] o_cnt [2];

    arb_requester_if #(.DEPTH(DEPTH), .LEN_W(LEN_W)) if0 ();
    arb_requester_if #(.DEPTH(DEPTH), .LEN_W(LEN_W)) if1 ();

    arb_requester #(.DEPTH(DEPTH), .LEN_W(LEN_W), .TIMEOUT(TIMEOUT)) u0 (
        .clock (clk),
        .reset (rst_n),
        .bus   (if0.master)
    );
    arb_requester #(.DEPTH(DEPTH), .LEN_W(LEN_W), .TIMEOUT(TIMEOUT)) u1 (
        .clock (clk),
        .reset (rst_n),
        .bus   (if1.master)
    );

    assign if0.job_valid = jv[0];
    assign if1.job_valid = jv[1];
    assign if0.job_len   = jl[0];
    assign if1.job_len   = jl[1];
    assign if0.gnt = mode_arb ? (if0.req && !owner) : dg[0];
    assign if1.gnt = mode_arb ? (if1.req && owner)  : dg[1];

    assign o_req  = {if1.req, if0.req};
    assign o_beat = {if1.beat, if0.beat};
    assign o_last = {if1.last, if0.last};
    assign o_done = {if1.job_done, if0.job_done};
    assign o_to   = {if1.timeout, if0.timeout};
    assign o_busy = {if1.busy, if0.busy};
    assign o_rdy  = {if1.job_ready, if0.job_ready};
    assign g      = {if1.gnt, if0.gnt};
    assign o_idx[0] = if0.beat_idx;
    assign o_idx[1] = if1.beat_idx;
    assign o_cnt[0] = if0.fifo_count;
    assign o_cnt[1] = if1.fifo_count;

    // Round-robin arbiter: the owner keeps the grant while it requests; when
    // it drops req the other port takes over if it is requesting.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner <= 1'b0;
        end else if (!(owner ? o_req[1] : o_req[0])) begin
            owner <= owner ? !o_req[0] : o_req[1];
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Behavioural model: queue of job lengths plus the protocol phase.
    int m_q [2][$];
    int m_ph [2];
    int m_wait [2];
    int m_beats [2];
    int m_done [2];
    int m_to [2];

    // Logs for the directed literal checks
    int lg_beats [2];
    int lg_req [2];
    int lg_done [2];
    int lg_to [2];
    int lg_idx [2][$];
    int lg_last [2][$];
    int lg_dcnt [2][$];

    task automatic clear_logs();
        for (int i = 0; i < 2; i++) begin
            lg_beats[i] = 0; lg_req[i] = 0; lg_done[i] = 0; lg_to[i] = 0;
            lg_idx[i].delete(); lg_last[i].delete(); lg_dcnt[i].delete();
        end
    endtask

    task automatic step(input int i);
        int e_req, e_beat, e_idx, e_last, e_cnt, e_busy, e_rdy, head, nph;
        if (!rst_n) begin
            m_q[i].delete();
            m_ph[i] = P_IDLE; m_wait[i] = 0; m_beats[i] = 0; m_done[i] = 0; m_to[i] = 0;
        end
        head   = (m_q[i].size() > 0) ? m_q[i][0] : -1;
        e_req  = int'(m_ph[i] == P_REQ || m_ph[i] == P_XFER);
        e_beat = int'(m_ph[i] == P_XFER && g[i]);
        e_idx  = (e_beat != 0) ? m_beats[i] : 0;
        e_last = int'(e_beat != 0 && m_beats[i] == head);
        e_cnt  = m_q[i].size();
        e_busy = int'(m_ph[i] != P_IDLE || e_cnt != 0);
        e_rdy  = int'(e_cnt < DEPTH || e_last != 0);

        chk($sformatf("u%0d.req", i),        int'(o_req[i]),  e_req);
        chk($sformatf("u%0d.beat", i),       int'(o_beat[i]), e_beat);
        chk($sformatf("u%0d.beat_idx", i),   int'(o_idx[i]),  e_idx);
        chk($sformatf("u%0d.last", i),       int'(o_last[i]), e_last);
        chk($sformatf("u%0d.job_done", i),   int'(o_done[i]), m_done[i]);
        chk($sformatf("u%0d.timeout", i),    int'(o_to[i]),   m_to[i]);
        chk($sformatf("u%0d.busy", i),       int'(o_busy[i]), e_busy);
        chk($sformatf("u%0d.fifo_count", i), int'(o_cnt[i]),  e_cnt);
        chk($sformatf("u%0d.job_ready", i),  int'(o_rdy[i]),  e_rdy);

        if (rst_n) begin
            if (o_beat[i]) begin lg_beats[i]++; lg_idx[i].push_back(int'(o_idx[i])); end
            if (o_last[i]) lg_last[i].push_back(int'(o_idx[i]));
            if (o_done[i]) begin lg_done[i]++; lg_dcnt[i].push_back(int'(o_cnt[i])); end
            if (o_to[i]) lg_to[i]++;
            if (o_req[i]) lg_req[i]++;

            // Advance to the state after the coming rising edge.
            nph = m_ph[i];
            m_done[i] = 0;
            m_to[i] = 0;
            case (m_ph[i])
                P_IDLE: if (e_cnt != 0) begin nph = P_REQ; m_wait[i] = 0; end
                P_REQ: begin
                    if (g[i]) begin
                        nph = P_XFER; m_beats[i] = 0;
                    end else begin
                        m_wait[i]++;
                        if (m_wait[i] == TIMEOUT) begin nph = P_REL; m_to[i] = 1; end
                    end
                end
                P_XFER: begin
                    if (e_last != 0) begin nph = P_REL; m_done[i] = 1; end
                    else if (e_beat != 0) m_beats[i]++;
                end
                default: begin nph = (e_cnt != 0) ? P_REQ : P_IDLE; m_wait[i] = 0; end
            endcase
            if (e_last != 0) void'(m_q[i].pop_front());
            if (jv[i] && e_rdy != 0) m_q[i].push_back(int'(jl[i]));
            m_ph[i] = nph;
        end
    endtask

    always @(negedge clk) begin
        step(0);
        step(1);
        if (mode_arb) chk("beat_overlap", int'(o_beat[0] & o_beat[1]), 0);
    end

    task automatic push(input int i, input int len);
        int n;
        bit ok;
        n = 0;
        ok = 1'b0;
        jl[i] = LEN_W'(len);
        jv[i] = 1'b1;
        while (!ok && n < 200) begin
            @(negedge clk);
            ok = o_rdy[i];
            n++;
            @(posedge clk);
            #1;
        end
        jv[i] = 1'b0;
        if (!ok) chk($sformatf("push%0d_accept", i), 0, 1);
    endtask

    task automatic wait_idle(input int i, input int maxc);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (o_busy[i] && n < maxc);
        chk($sformatf("u%0d.reach_idle", i), int'(o_busy[i]), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int ex[5];
        int n;
        jl[0] = '0;
        jl[1] = '0;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single job, len 3, grant held
        clear_logs();
        dg[0] = 1'b1;
        push(0, 3);
        wait_idle(0, 100);
        chk("A.beats", lg_beats[0], 4);
        for (int k = 0; k < 4; k++)
            chk($sformatf("A.idx%0d", k), (k < lg_idx[0].size()) ? lg_idx[0][k] : -1, k);
        chk("A.last_n", lg_last[0].size(), 1);
        chk("A.last_idx", (lg_last[0].size() > 0) ? lg_last[0][0] : -1, 3);
        chk("A.done_n", lg_done[0], 1);
        chk("A.req_cycles", lg_req[0], 5);

        // Grant toggling 1,0,0,1,1 during XFER of a 3-beat job
        clear_logs();
        dg[0] = 1'b0;
        push(0, 2);
        @(posedge clk);
        #1;
        ex = '{1, 1, 0, 0, 1};
        for (int k = 0; k < 5; k++) begin
            dg[0] = ex[k][0];
            @(posedge clk);
            #1;
        end
        dg[0] = 1'b1;
        @(posedge clk);
        #1;
        dg[0] = 1'b0;
        wait_idle(0, 50);
        chk("B.beats", lg_beats[0], 3);
        chk("B.done_n", lg_done[0], 1);
        chk("B.req_cycles", lg_req[0], 6);

        // Five jobs into a 4-deep queue
        clear_logs();
        dg[0] = 1'b0;
        push(0, 1);
        push(0, 0);
        push(0, 3);
        push(0, 2);
        @(negedge clk);
        chk("C.ready_full", int'(o_rdy[0]), 0);
        chk("C.count_full", int'(o_cnt[0]), 4);
        @(posedge clk);
        #1;
        dg[0] = 1'b1;
        push(0, 2);
        wait_idle(0, 200);
        ex = '{1, 0, 3, 2, 2};
        chk("C.jobs", lg_last[0].size(), 5);
        for (int k = 0; k < 5; k++)
            chk($sformatf("C.len%0d", k), (k < lg_last[0].size()) ? lg_last[0][k] : -1, ex[k]);
        ex = '{4, 3, 2, 1, 0};
        for (int k = 0; k < 5; k++)
            chk($sformatf("C.cnt_at_done%0d", k), (k < lg_dcnt[0].size()) ? lg_dcnt[0][k] : -1, ex[k]);

        // Grant withheld: timeout and retry
        clear_logs();
        dg[0] = 1'b0;
        push(0, 0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!o_to[0] && n < 40);
        chk("D.timeout_seen", int'(o_to[0]), 1);
        chk("D.req_before_to", lg_req[0], TIMEOUT);
        chk("D.req_in_rel", int'(o_req[0]), 0);
        chk("D.count_kept", int'(o_cnt[0]), 1);
        @(negedge clk);
        chk("D.req_retry", int'(o_req[0]), 1);
        @(posedge clk);
        #1;
        dg[0] = 1'b1;
        wait_idle(0, 50);

        // Reset mid-transfer at beat_idx 2
        dg[0] = 1'b1;
        push(0, 5);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(o_beat[0] && o_idx[0] == LEN_W'(2)) && n < 40);
        chk("E.reached_idx2", int'(o_idx[0]), 2);
        #2 rst_n = 1'b0;
        #1;
        chk("E.req_async", int'(o_req[0]), 0);
        chk("E.beat_async", int'(o_beat[0]), 0);
        chk("E.count_async", int'(o_cnt[0]), 0);
        @(negedge clk);
        @(posedge clk);
        #3 rst_n = 1'b1;
        dg[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("E.busy_after", int'(o_busy[0]), 0);
        chk("E.ready_after", int'(o_rdy[0]), 1);
        chk("E.req_after", int'(o_req[0]), 0);

        // Two instances sharing the arbiter
        clear_logs();
        mode_arb = 1'b1;
        jl[0] = LEN_W'(1);
        jl[1] = LEN_W'(1);
        jv = 2'b11;
        @(posedge clk);
        #1;
        jv = 2'b00;
        wait_idle(0, 100);
        wait_idle(1, 100);
        chk("F.done0", lg_done[0], 1);
        chk("F.done1", lg_done[1], 1);
        chk("F.beats0", lg_beats[0], 2);
        chk("F.beats1", lg_beats[1], 2);

        // Randomized traffic, checked cycle by cycle against the model
        for (int blk = 0; blk < 12; blk++) begin
            int pg;
            mode_arb = 1'($urandom_range(0, 1));
            pg = $urandom_range(0, 4);
            for (int c = 0; c < 250; c++) begin
                for (int i = 0; i < 2; i++) begin
                    jv[i] = ($urandom_range(0, 3) == 0);
                    jl[i] = LEN_W'($urandom_range(0, (1 << LEN_W) - 1));
                    dg[i] = ($urandom_range(0, 3) < pg);
                end
                if (blk == 6 && c == 100) begin
                    #3 rst_n = 1'b0;
                    @(negedge clk);
                    @(posedge clk);
                    #3 rst_n = 1'b1;
                end
                @(posedge clk);
                #1;
            end
        end

        // Drain everything still queued
        jv = 2'b00;
        mode_arb = 1'b0;
        dg = 2'b11;
        wait_idle(0, 300);
        wait_idle(1, 300);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
